// File: rtl/mac_accum_if.sv
// Bundle between the multiplier-side controller and the product accumulator:
// job control, the product stream and the result handshake.
interface mac_accum_if #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic               clr;
  logic               start;
  logic [CNT_W-1:0]   len;
  logic [2*SIZE-1:0]  prod;
  logic               prod_valid;
  logic               busy;
  logic [ACC_W-1:0]   sum;
  logic               sum_valid;
  logic               sum_ready;
  logic               ovf;

  modport master (
    output clr, start, len, prod, prod_valid, sum_ready,
    input  busy, sum, sum_valid, ovf
  );

  modport slave (
    input  clr, start, len, prod, prod_valid, sum_ready,
    output busy, sum, sum_valid, ovf
  );
endinterface

// File: rtl/mac_accum.sv
// Saturating accumulator for a programmed count of multiplier products; the
// finished sum is offered on a valid/ready handshake with a sticky overflow flag.
module mac_accum #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  mac_accum_if.slave bus
);
  localparam int PW = 2 * SIZE;
  localparam logic [ACC_W-1:0] SUM_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] sum_reg, sum_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg;
  logic             valid_reg;
  logic [ACC_W:0]   add_full;

  // One extra bit catches the carry that signals saturation.
  assign add_full = {1'b0, sum_reg} + {{(ACC_W + 1 - PW){1'b0}}, bus.prod};

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;

    if (bus.clr) begin
      state_next = IDLE;
      sum_next   = '0;
      ovf_next   = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sum_next   = '0;
            ovf_next   = 1'b0;
            cnt_next   = bus.len;
            state_next = (bus.len != '0) ? ACC : DONE;
          end
        end
        ACC: begin
          if (bus.prod_valid) begin
            if (add_full[ACC_W]) begin
              sum_next = SUM_MAX;
              ovf_next = 1'b1;
            end else begin
              sum_next = add_full[ACC_W-1:0];
            end
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (bus.sum_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // busy/sum_valid are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_next == DONE);
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.sum       = sum_reg;
  assign bus.sum_valid = valid_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_mac_accum.sv
// Drives two accumulators (24-bit and 17-bit sums) with identical streams;
// expected results are queued per job and checked by an output monitor.
module tb_mac_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        prod_valid = 1'b0;
  logic        sum_ready = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] prod = '0;

  always #5 clk = ~clk;

  mac_accum_if #(.SIZE(8), .ACC_W(24), .CNT_W(8)) ia ();
  mac_accum_if #(.SIZE(8), .ACC_W(17), .CNT_W(8)) ib ();

  assign ia.clr = clr;
  assign ia.start = start;
  assign ia.len = len;
  assign ia.prod = prod;
  assign ia.prod_valid = prod_valid;
  assign ia.sum_ready = sum_ready;
  assign ib.clr = clr;
  assign ib.start = start;
  assign ib.len = len;
  assign ib.prod = prod;
  assign ib.prod_valid = prod_valid;
  assign ib.sum_ready = sum_ready;

  mac_accum #(.SIZE(8), .ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mac_accum #(.SIZE(8), .ACC_W(17), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    longint sum;
    bit     ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   prods[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Reference: plain sum of the job's products, clipped at the sum width.
  function automatic exp_t model(input int aw, input int n);
    exp_t   r;
    longint total = 0;
    longint mx;
    mx = (longint'(1) << aw) - 1;
    for (int i = 0; i < n; i++) total += prods[i];
    r.sum = (total > mx) ? mx : total;
    r.ovf = (total > mx);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  exp_t cur_a, cur_b;
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;

  always @(negedge clk) begin
    if (ia.sum_valid) begin
      if (!prev_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_result got sum=%0d expected no result", ia.sum);
        end else begin
          cur_a = qa.pop_front();
          check("a_sum", ia.sum, cur_a.sum);
          check("a_ovf", ia.ovf, cur_a.ovf);
        end
      end else begin
        check("a_sum_hold", ia.sum, cur_a.sum);
        check("a_ovf_hold", ia.ovf, cur_a.ovf);
      end
    end
    prev_a = ia.sum_valid;

    if (ib.sum_valid) begin
      if (!prev_b) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_result got sum=%0d expected no result", ib.sum);
        end else begin
          cur_b = qb.pop_front();
          check("b_sum", ib.sum, cur_b.sum);
          check("b_ovf", ib.ovf, cur_b.ovf);
        end
      end else begin
        check("b_sum_hold", ib.sum, cur_b.sum);
        check("b_ovf_hold", ib.ovf, cur_b.ovf);
      end
    end
    prev_b = ib.sum_valid;
  end

  // Runs one complete job over prods[0..n-1], then holds DONE for `hold`
  // cycles of ignored start/prod pulses before completing the handshake.
  task automatic do_job(input int n, input int gmin, input int gmax, input int hold);
    exp_t ea, eb;
    ea = model(24, n);
    eb = model(17, n);
    qa.push_back(ea);
    qb.push_back(eb);
    start = 1'b1;
    len = 8'(n);
    prod_valid = 1'b1;
    prod = 16'hBEEF;
    step();
    start = 1'b0;
    prod_valid = 1'b0;
    if (n == 0) check("len0_valid", ia.sum_valid, 1);
    for (int i = 0; i < n; i++) begin
      check("acc_busy", ia.busy, 1);
      repeat ($urandom_range(gmin, gmax)) begin
        prod_valid = 1'b0;
        prod = 16'($urandom);
        sum_ready = 1'($urandom);
        step();
        check("gap_busy", ia.busy, 1);
        check("gap_no_valid", ia.sum_valid, 0);
      end
      prod_valid = 1'b1;
      prod = 16'(prods[i]);
      sum_ready = 1'($urandom);
      step();
      prod_valid = 1'b0;
      sum_ready = 1'b0;
      check("beat_valid", ia.sum_valid, (i == n - 1) ? 1 : 0);
    end
    repeat (hold) begin
      start = 1'($urandom);
      len = 8'($urandom);
      prod_valid = 1'b1;
      prod = 16'd100;
      step();
      check("done_hold_a", ia.sum_valid, 1);
      check("done_hold_b", ib.sum_valid, 1);
    end
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 16'd100;
    sum_ready = 1'b1;
    step();
    prod_valid = 1'b0;
    sum_ready = 1'b0;
    check("handshake_drop_a", ia.sum_valid, 0);
    check("handshake_drop_b", ib.sum_valid, 0);
    check("idle_busy", ia.busy, 0);
    check("sum_kept_a", ia.sum, ea.sum);
    check("sum_kept_b", ib.sum, eb.sum);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    check("rst_sum", ia.sum, 0);
    check("rst_valid", ia.sum_valid, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_ovf", ia.ovf, 0);
    rst = 1'b1;
    step();

    // Basic job with one idle cycle before each beat.
    prods = '{65025, 6, 0, 65535};
    do_job(4, 1, 1, 5);
    check("basic_sum", ia.sum, 130566);
    check("basic_ovf", ia.ovf, 0);

    // Long job: fits in 24 bits, saturates the 17-bit instance.
    prods.delete();
    repeat (255) prods.push_back(65535);
    do_job(255, 0, 0, 1);
    check("long_sum_a", ia.sum, 16711425);
    check("long_ovf_a", ia.ovf, 0);
    check("long_sum_b", ib.sum, 131071);
    check("long_ovf_b", ib.ovf, 1);

    prods = '{65535, 65535, 65535};
    do_job(3, 0, 0, 0);
    check("sat3_sum_a", ia.sum, 196605);
    check("sat3_sum_b", ib.sum, 131071);
    check("sat3_ovf_b", ib.ovf, 1);

    // Zero-length job.
    prods.delete();
    do_job(0, 0, 0, 2);
    check("len0_sum", ia.sum, 0);

    // clr beats a simultaneous beat and start.
    start = 1'b1;
    len = 8'd4;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 16'd1000;
    step();
    prod = 16'd2000;
    step();
    clr = 1'b1;
    start = 1'b1;
    len = 8'd5;
    prod = 16'd500;
    step();
    clr = 1'b0;
    start = 1'b0;
    prod_valid = 1'b0;
    check("clr_busy", ia.busy, 0);
    check("clr_sum", ia.sum, 0);
    check("clr_valid", ia.sum_valid, 0);
    check("clr_ovf_b", ib.ovf, 0);
    step();
    check("clr_start_ignored", ia.busy, 0);

    // Asynchronous reset in the middle of a job.
    start = 1'b1;
    len = 8'd3;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 16'd40000;
    step();
    step();
    prod_valid = 1'b0;
    check("pre_rst_sum", ia.sum, 80000);
    #2 rst = 1'b0;
    #1;
    check("arst_sum", ia.sum, 0);
    check("arst_busy", ia.busy, 0);
    check("arst_valid", ia.sum_valid, 0);
    check("arst_ovf", ia.ovf, 0);
    check("arst_sum_b", ib.sum, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_busy", ia.busy, 0);
    prods = '{7, 8, 9};
    do_job(3, 0, 2, 1);

    // Randomized jobs, biased towards large products to exercise saturation.
    for (int j = 0; j < 25; j++) begin
      n = int'($urandom_range(0, 12));
      prods.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) prods.push_back(int'($urandom_range(0, 65535)));
        else prods.push_back(int'($urandom_range(40000, 65535)));
      end
      do_job(n, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    step();
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
